// File: rtl/fifth_boot_if.sv
// fifth_boot_if: byte stream in, code RAM write port and CPU control out of the boot loader.
interface fifth_boot_if #(parameter int ADDR_W = 13) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              load_req;
  logic              code_we;
  logic [ADDR_W-1:0] code_waddr;
  logic [15:0]       code_wdata;
  logic              cpu_reset_n;
  logic              busy;
  logic              done;
  logic              error;
  modport master (
    output rx_valid, rx_data, load_req,
    input  rx_ready, code_we, code_waddr, code_wdata, cpu_reset_n, busy, done, error
  );
  modport slave (
    input  rx_valid, rx_data, load_req,
    output rx_ready, code_we, code_waddr, code_wdata, cpu_reset_n, busy, done, error
  );
endinterface

// File: rtl/fifth_boot_loader.sv
// fifth_boot_loader: loads a byte-stream image into code RAM, then releases the CPU reset.
// Define FIFTH_BOOT_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module fifth_boot_loader #(parameter int ADDR_W = 13) (
  input logic clk,
  input logic reset,
  fifth_boot_if.slave bus
);
  typedef enum logic [2:0] {S_CNT_LO, S_CNT_HI, S_DAT_LO, S_DAT_HI, S_CSUM, S_FLUSH, S_RUN, S_ERR} state_t;
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;
  state_t state, next_state;
  logic [15:0] n, cnt;
  logic [7:0] lo;
  logic [ADDR_W-1:0] idx;
  logic xfer, last, sum_ok;
  assign xfer = bus.rx_valid & bus.rx_ready;
  assign cnt = {bus.rx_data, n[7:0]};
  assign last = 16'(idx) == n - 16'd1;
`ifdef FIFTH_BOOT_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
  logic [7:0] sum;
  assign sum_ok = 8'(sum + bus.rx_data) == 8'd0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sum <= '0;
    else sum <= bus.load_req ? 8'd0 : xfer ? 8'(sum + bus.rx_data) : sum;
`else
  localparam state_t S_TAIL = S_FLUSH;
  assign sum_ok = 1'b1;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_CNT_LO;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (bus.load_req) next_state = S_CNT_LO;
    else if (xfer)
      case (state)
        S_CNT_LO: next_state = S_CNT_HI;
        S_CNT_HI: next_state = ({1'b0, cnt} > MAX_WORDS) ? S_ERR : (cnt == 16'd0) ? S_TAIL : S_DAT_LO;
        S_DAT_LO: next_state = S_DAT_HI;
        S_DAT_HI: next_state = last ? S_TAIL : S_DAT_LO;
        S_CSUM:   next_state = sum_ok ? S_FLUSH : S_ERR;
        default:  next_state = state;
      endcase
    else if (state == S_FLUSH) next_state = S_RUN;
  end
  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.rx_ready    <= 1'b1;
      bus.busy        <= 1'b1;
      bus.cpu_reset_n <= 1'b0;
      bus.done        <= 1'b0;
      bus.error       <= 1'b0;
    end else begin
      bus.rx_ready    <= next_state inside {S_CNT_LO, S_CNT_HI, S_DAT_LO, S_DAT_HI, S_CSUM};
      bus.busy        <= next_state inside {S_CNT_LO, S_CNT_HI, S_DAT_LO, S_DAT_HI, S_CSUM, S_FLUSH};
      bus.cpu_reset_n <= next_state == S_RUN;
      bus.done        <= next_state == S_RUN;
      bus.error       <= next_state == S_ERR;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      n              <= '0;
      lo             <= '0;
      idx            <= '0;
      bus.code_we    <= 1'b0;
      bus.code_waddr <= '0;
      bus.code_wdata <= '0;
    end else begin
      bus.code_we <= !bus.load_req && xfer && state == S_DAT_HI;
      if (bus.load_req) idx <= '0;
      else if (xfer) begin
        if (state == S_CNT_LO) n[7:0] <= bus.rx_data;
        if (state == S_CNT_HI) n[15:8] <= bus.rx_data;
        if (state == S_DAT_LO) lo <= bus.rx_data;
        if (state == S_DAT_HI) begin
          bus.code_waddr <= idx;
          bus.code_wdata <= {bus.rx_data, lo};
          idx            <= idx + 1'b1;
        end
      end
    end
endmodule
